bp_resolve_queue: RTL and testbench

//  In-order queue of branch predictions made at fetch. Checks each one against the

---
 rtl/bp_resolve_queue.sv | 124 ++++++++++++
 tb/tb_bp_resolve_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch-time branch predictions, resolved against execute outcomes.
// Latency: resolve -> upd/mispredict/err/redirect exactly 1 cycle (registered outputs).
// Backpressure: push_ready = !full, no same-cycle pop bypass; flush/mispredict drop pushes.
module bp_resolve_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [31:0]              push_pc,
    input  logic                     push_taken,
    input  logic [31:0]              push_target,

    input  logic                     resolve_valid,
    input  logic [31:0]              resolve_pc,
    input  logic                     resolve_taken,
    input  logic [31:0]              resolve_target,

    input  logic                     flush,

    output logic                     upd_valid,
    output logic [31:0]              upd_pc,
    output logic                     upd_taken,
    output logic [31:0]              upd_dest,

    output logic                     mispredict,
    output logic [31:0]              redirect_pc,
    output logic                     err,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CW       = PTR_BITS + 1;

    // One outstanding prediction as captured at fetch.
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_BITS:0] head;
    logic [PTR_BITS:0] tail;

    entry_t            head_ent;
    logic              pop_hit;
    logic              mispred_now;
    logic              clear_q;
    logic              push_acc;
    logic [31:0]       redirect_nxt;

    // Pointers carry a wrap bit, so occupancy is a plain difference.
    assign count      = tail - head;
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign push_ready = !full;
    assign head_ent   = mem[head[PTR_BITS-1:0]];

    // Resolve decode: match against the oldest entry, classify the outcome, gate pushes.
    always_comb begin
        pop_hit      = resolve_valid && !empty && (resolve_pc == head_ent.pc);
        mispred_now  = pop_hit &&
                       ((head_ent.taken != resolve_taken) ||
                        (resolve_taken && (head_ent.target != resolve_target)));
        // Everything behind a mispredicted branch is wrong-path, same as a flush.
        clear_q      = flush || mispred_now;
        push_acc     = push_valid && push_ready && !clear_q;
        // Not-taken fall-through skips the delay slot.
        redirect_nxt = resolve_taken ? resolve_target : (resolve_pc + 32'd8);
    end

    // Head/tail pointer update; clearing collapses head onto tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else if (clear_q) begin
            head <= tail;
        end else begin
            if (push_acc) tail <= tail + CW'(1);
            if (pop_hit)  head <= head + CW'(1);
        end
    end

    // Entry storage write at tail; contents are never cleared.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem[tail[PTR_BITS-1:0]] <= '{pc: push_pc, taken: push_taken, target: push_target};
        end
    end

    // Registered BHT training, redirect and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            upd_dest    <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            err         <= 1'b0;
        end else begin
            upd_valid  <= pop_hit;
            mispredict <= mispred_now;
            err        <= resolve_valid && !pop_hit;
            if (pop_hit) begin
                upd_pc    <= resolve_pc;
                upd_taken <= resolve_taken;
                upd_dest  <= resolve_target;
            end
            // Redirect is only meaningful alongside mispredict; otherwise it holds.
            if (mispred_now) begin
                redirect_pc <= redirect_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
module tb_bp_resolve_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid, push_ready, push_taken;
    logic [31:0] push_pc, push_target;
    logic        resolve_valid, resolve_taken;
    logic [31:0] resolve_pc, resolve_target;
    logic        flush;
    logic        upd_valid, upd_taken, mispredict, err, empty, full;
    logic [31:0] upd_pc, upd_dest, redirect_pc;
    logic [3:0]  count;

    always #5 clk = ~clk;

    bp_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_taken(push_taken), .push_target(push_target),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .flush(flush),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_dest(upd_dest),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .err(err),
        .count(count), .empty(empty), .full(full)
    );

    // Reference model: a plain queue of outstanding predictions plus expected outputs.
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ment_t;

    ment_t       mq[$];
    logic        e_upd_valid, e_upd_taken, e_mis, e_err;
    logic [31:0] e_upd_pc, e_upd_dest, e_redir;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit hit, mis, room;
        if (reset) begin
            mq.delete();
            e_upd_valid = 0; e_upd_taken = 0; e_mis = 0; e_err = 0;
            e_upd_pc = 0; e_upd_dest = 0; e_redir = 0;
            return;
        end
        room = (mq.size() < DEPTH);
        hit  = resolve_valid && (mq.size() > 0) && (mq[0].pc == resolve_pc);
        mis  = 0;
        e_err       = resolve_valid && !hit;
        e_upd_valid = hit;
        if (hit) begin
            e_upd_pc    = resolve_pc;
            e_upd_taken = resolve_taken;
            e_upd_dest  = resolve_target;
            if (mq[0].taken != resolve_taken) mis = 1;
            if (resolve_taken && (mq[0].target != resolve_target)) mis = 1;
            if (mis) e_redir = resolve_taken ? resolve_target : resolve_pc + 32'd8;
        end
        e_mis = mis;
        if (flush || mis) begin
            mq.delete();
        end else begin
            if (hit) void'(mq.pop_front());
            if (push_valid && room) mq.push_back('{push_pc, push_taken, push_target});
        end
    endtask

    task automatic compare_all();
        chk("upd_valid",  upd_valid,  e_upd_valid);
        chk("mispredict", mispredict, e_mis);
        chk("err",        err,        e_err);
        chk("redirect_pc", redirect_pc, e_redir);
        chk("count",      count,      mq.size());
        chk("empty",      empty,      mq.size() == 0);
        chk("full",       full,       mq.size() == DEPTH);
        chk("push_ready", push_ready, mq.size() < DEPTH);
        if (e_upd_valid) begin
            chk("upd_pc",    upd_pc,    e_upd_pc);
            chk("upd_taken", upd_taken, e_upd_taken);
            chk("upd_dest",  upd_dest,  e_upd_dest);
        end
    endtask

    // One clock: model consumes current inputs, DUT clocks, outputs checked 1ns later.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        reset = 0; flush = 0;
        push_valid = 0; push_pc = 0; push_taken = 0; push_target = 0;
        resolve_valid = 0; resolve_pc = 0; resolve_taken = 0; resolve_target = 0;
    endtask

    task automatic do_push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        push_valid = 1; push_pc = pc; push_taken = t; push_target = tg;
    endtask

    task automatic do_res(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        resolve_valid = 1; resolve_pc = pc; resolve_taken = t; resolve_target = tg;
    endtask

    // Directed vectors: inputs for one cycle and the outputs required after that edge.
    typedef struct {
        logic        pv;  logic [31:0] ppc; logic pt; logic [31:0] ptg;
        logic        rv;  logic [31:0] rpc; logic rt; logic [31:0] rtg;
        logic        fl;
        logic        x_upd; logic x_mis; logic [31:0] x_redir; logic x_err; int x_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkv(input logic pv, input logic [31:0] ppc, input logic pt,
                                 input logic [31:0] ptg, input logic rv, input logic [31:0] rpc,
                                 input logic rt, input logic [31:0] rtg, input logic fl,
                                 input logic xu, input logic xm, input logic [31:0] xr,
                                 input logic xe, input int xc);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.pt = pt; v.ptg = ptg;
        v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtg = rtg; v.fl = fl;
        v.x_upd = xu; v.x_mis = xm; v.x_redir = xr; v.x_err = xe; v.x_cnt = xc;
        return v;
    endfunction

    initial begin
        //                 push                    resolve                  fl  upd mis redir   err cnt
        vt.push_back(mkv(1, 32'h100, 1, 32'h200,  0, 0,       0, 0,        0,  0,  0,  0,      0,  1));
        vt.push_back(mkv(0, 0,       0, 0,        1, 32'h100, 1, 32'h200,  0,  1,  0,  0,      0,  0));
        vt.push_back(mkv(1, 32'h100, 0, 32'h0,    0, 0,       0, 0,        0,  0,  0,  0,      0,  1));
        vt.push_back(mkv(1, 32'h110, 1, 32'h400,  0, 0,       0, 0,        0,  0,  0,  0,      0,  2));
        vt.push_back(mkv(1, 32'h120, 0, 32'h0,    0, 0,       0, 0,        0,  0,  0,  0,      0,  3));
        vt.push_back(mkv(1, 32'h130, 1, 32'h500,  0, 0,       0, 0,        0,  0,  0,  0,      0,  4));
        vt.push_back(mkv(1, 32'h150, 1, 32'h600,  1, 32'h100, 1, 32'h300,  0,  1,  1,  32'h300, 0, 0));
        vt.push_back(mkv(1, 32'h100, 1, 32'h200,  0, 0,       0, 0,        0,  0,  0,  0,      0,  1));
        vt.push_back(mkv(0, 0,       0, 0,        1, 32'h100, 0, 32'h200,  0,  1,  1,  32'h108, 0, 0));
        vt.push_back(mkv(0, 0,       0, 0,        1, 32'h100, 1, 32'h200,  0,  0,  0,  0,      1,  0));
        vt.push_back(mkv(1, 32'h100, 1, 32'h200,  0, 0,       0, 0,        0,  0,  0,  0,      0,  1));
        vt.push_back(mkv(0, 0,       0, 0,        1, 32'h104, 1, 32'h200,  0,  0,  0,  0,      1,  1));
        vt.push_back(mkv(1, 32'h140, 0, 32'h0,    1, 32'h100, 1, 32'h200,  0,  1,  0,  0,      0,  1));
        vt.push_back(mkv(0, 0,       0, 0,        1, 32'h140, 0, 32'h999,  0,  1,  0,  0,      0,  0));

        // Reset state.
        idle();
        reset = 1;
        cycle();
        cycle();
        chk("rst_upd_pc",   upd_pc,   32'h0);
        chk("rst_upd_dest", upd_dest, 32'h0);
        chk("rst_upd_taken", upd_taken, 1'b0);
        idle();

        // Directed table.
        foreach (vt[i]) begin
            idle();
            if (vt[i].pv) do_push(vt[i].ppc, vt[i].pt, vt[i].ptg);
            if (vt[i].rv) do_res(vt[i].rpc, vt[i].rt, vt[i].rtg);
            flush = vt[i].fl;
            cycle();
            chk($sformatf("vec%0d_upd", i),   upd_valid,  vt[i].x_upd);
            chk($sformatf("vec%0d_mis", i),   mispredict, vt[i].x_mis);
            chk($sformatf("vec%0d_err", i),   err,        vt[i].x_err);
            chk($sformatf("vec%0d_count", i), count,      vt[i].x_cnt);
            if (vt[i].x_mis) chk($sformatf("vec%0d_redir", i), redirect_pc, vt[i].x_redir);
        end

        // Fill to full, overflow push ignored, push+pop at full cannot push.
        for (int i = 0; i < DEPTH; i++) begin
            idle(); do_push(32'h1000 + 32'(i) * 4, 1, 32'h2000 + 32'(i)); cycle();
        end
        chk("fill_full", full, 1'b1);
        chk("fill_ready", push_ready, 1'b0);
        idle(); do_push(32'h1fff0, 1, 32'h0); cycle();
        chk("overflow_count", count, 4'd8);
        idle(); do_push(32'h1fff4, 1, 32'h0); do_res(32'h1000, 1, 32'h2000); cycle();
        chk("full_pushpop_count", count, 4'd7);
        idle(); do_push(32'h1fff8, 0, 32'h0); do_res(32'h1004, 1, 32'h2001); cycle();
        chk("pushpop_count", count, 4'd7);
        // Drain in order.
        for (int i = 2; i < DEPTH; i++) begin
            idle(); do_res(32'h1000 + 32'(i) * 4, 1, 32'h2000 + 32'(i)); cycle();
            chk("drain_upd_pc", upd_pc, 32'h1000 + 32'(i) * 4);
        end
        idle(); do_res(32'h1fff8, 0, 32'h0); cycle();
        chk("drain_empty", empty, 1'b1);

        // Wrap: 20 push/pop pairs through a one-deep backlog.
        idle(); do_push(32'h3000, 0, 32'h0); cycle();
        for (int i = 0; i < 20; i++) begin
            idle();
            do_push(32'h3004 + 32'(i) * 4, 0, 32'h0);
            do_res(32'h3000 + 32'(i) * 4, 0, 32'h0);
            cycle();
            chk("wrap_upd_pc", upd_pc, 32'h3000 + 32'(i) * 4);
        end
        idle(); do_res(32'h3050, 0, 32'h0); cycle();

        // Flush with 5 entries, same-cycle good resolve and push.
        for (int i = 0; i < 5; i++) begin
            idle(); do_push(32'h5000 + 32'(i) * 4, 1, 32'h6000); cycle();
        end
        idle(); flush = 1; do_res(32'h5000, 1, 32'h6000); do_push(32'h5100, 1, 32'h6000); cycle();
        chk("flush_upd", upd_valid, 1'b1);
        chk("flush_count", count, 4'd0);

        // Reset mid-operation with a same-cycle resolve and push.
        for (int i = 0; i < 3; i++) begin
            idle(); do_push(32'h7000 + 32'(i) * 4, 0, 32'h0); cycle();
        end
        idle(); reset = 1; do_res(32'h7000, 1, 32'h8000); do_push(32'h7100, 0, 32'h0); cycle();
        chk("midrst_mis", mispredict, 1'b0);
        chk("midrst_count", count, 4'd0);
        idle(); cycle();
        chk("midrst_late_upd", upd_valid, 1'b0);

        // Randomized traffic against the model; first half resolve-light to reach full.
        for (int i = 0; i < 3000; i++) begin
            int rpct;
            idle();
            rpct  = (i < 1500) ? 25 : 45;
            reset = ($urandom_range(0, 399) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) < 60)
                do_push(32'($urandom_range(0, 1023)) << 2, 1'($urandom_range(0, 1)),
                        32'h4000 + (32'($urandom_range(0, 3)) << 4));
            if ($urandom_range(0, 99) < rpct) begin
                if (mq.size() > 0 && $urandom_range(0, 9) < 9) begin
                    do_res(mq[0].pc, mq[0].taken, mq[0].target);
                    if ($urandom_range(0, 9) < 2) resolve_taken = ~resolve_taken;
                    if ($urandom_range(0, 9) < 2)
                        resolve_target = 32'h4000 + (32'($urandom_range(0, 3)) << 4);
                end else begin
                    do_res(32'($urandom_range(0, 1023)) << 2, 1'($urandom_range(0, 1)),
                           32'h4000 + (32'($urandom_range(0, 3)) << 4));
                end
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
